boe_frame_tx: RTL and testbench
===============================

BOE_FRAME_TX -- requirements
Module: boe_frame_tx

Interface
REQ-001 The block SHALL have parameter MAX_N, default 6, meaning maximum samples per frame, fixed to 6 by the BOE protocol.
REQ-002 The block SHALL have parameter WAIT_CYC, default 1, meaning idle cycles between the last sent sample and the first result capture.
REQ-003 The block SHALL have port clk, input, 1, single clock with all logic on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports in_valid/in_last/in_data[7:0] (inputs) and in_ready (output) forming the upstream sample handshake; in_last marks the frame's final sample.
REQ-006 The block SHALL have outputs data_num[2:0] and data_in[7:0] driving the BOE input side, and input result[10:0] from the BOE output side.
REQ-007 The block SHALL have outputs out_n[2:0], out_max[7:0], out_sum[10:0], out_sort[47:0], done and err; out_sort holds element k in bits [8k+7:8k], ascending.

Function
REQ-008 The FSM SHALL implement states IDLE, LOAD, SEND, WAIT, CAPT and DONE, with transitions IDLE->LOAD->SEND->WAIT->CAPT->DONE->IDLE and no other transitions.
REQ-009 IDLE SHALL last one cycle and clear the sample count.
REQ-010 In LOAD, in_ready SHALL be 1 and each in_valid&in_ready cycle SHALL store in_data at buf[count] and increment count.
REQ-011 LOAD SHALL exit to SEND after accepting a sample with in_last=1, or after the MAX_N-th sample regardless of in_last; N = count, with 1<=N<=6.
REQ-012 in_ready SHALL be 0 in every state except LOAD; LOAD SHALL wait indefinitely while in_valid=0.
REQ-013 SEND SHALL last exactly N cycles and drive data_in=buf[i] in cycle i, with data_num=N in cycle 0 and data_num=0 in all other cycles.
REQ-014 Outside SEND, data_num and data_in SHALL both be 0.
REQ-015 WAIT SHALL last WAIT_CYC cycles.
REQ-016 CAPT SHALL last N+2 cycles and register result at the end of capture cycle j as follows: j=0 gives max into out_max using result[7:0]; j=1 gives sum into out_sum; j=2..N+1 gives out_sort element j-2 using result[7:0].
REQ-017 At CAPT entry, out_sort elements N..5 SHALL be set to 8'hFF.
REQ-018 DONE SHALL last one cycle with done=1; out_n=N at that point.
REQ-019 out_* SHALL hold their values until overwritten in the next CAPT.
REQ-020 A frame SHALL occupy N+WAIT_CYC+N+2 cycles from the first data_num to done, and the next data_num SHALL be no earlier than 2 cycles after done, matching BOE's return to its read state.
REQ-021 Sum width SHALL be 11 bits; the maximum frame sum of 6*255=1530 does not overflow.

Reset
REQ-022 While rst=0, the state SHALL be IDLE; count, buf, data_num, data_in, in_ready, done, err, out_n, out_max and out_sum SHALL be 0, and out_sort SHALL be all 8'hFF.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no done pulse and discard partial captures; the first cycle after release SHALL be IDLE.

Configuration
REQ-024 With BOE_TX_CHECK_EN defined, the block SHALL compute the expected max and sum while in SEND.
REQ-025 With BOE_TX_CHECK_EN defined, err SHALL be set in DONE if out_max or out_sum mismatches, or if out_sort[0..N-1] is not non-decreasing, or if it is not a permutation-consistent min/max (element 0 <= every sample <= element N-1).
REQ-026 With BOE_TX_CHECK_EN defined, err SHALL be cleared on entering SEND.
REQ-027 Without BOE_TX_CHECK_EN, err SHALL be constant 0 and no check logic SHALL be present.

Structure
REQ-028 Package boe_pkg SHALL hold MAX_N, DATA_W=8, RES_W=11, NUM_W=3, the FSM state enum and the sort sentinel 8'hFF.
REQ-029 Sub-module boe_rx_capture SHALL contain the CAPT-phase result demux and output registers, with start/N inputs and a capture-complete output.

Verification
REQ-030 The bench SHALL drive samples 10,3,7,3,200,1 with in_last on the 6th: data_num=6 for one cycle; then out_max=200, out_sum=224, out_sort={1,3,3,7,10,200}, done for one cycle, err=0.
REQ-031 The bench SHALL drive a single sample 5 with in_last: N=1; data_num=1 for one cycle; out_max=5, out_sum=5, out_sort={5,FF,FF,FF,FF,FF}; done 4+WAIT_CYC cycles after data_num.
REQ-032 The bench SHALL drive 8 samples with no in_last: the frame SHALL close at 6 samples, in_ready=0 until done+1, and samples 7 and 8 SHALL be accepted as the next frame.
REQ-033 The bench SHALL drive 6 samples of 255: out_sum=1530 and out_max=255.
REQ-034 The bench SHALL assert rst low during CAPT of a 4-sample frame: no done, outputs return to reset values, and a following frame of 2,9 SHALL yield max=9, sum=11.
REQ-035 With BOE_TX_CHECK_EN defined, the bench SHALL force result during the sum capture cycle to 0 on a frame summing to 50: err=1 in DONE, cleared at the next SEND.

Source files
------------

// File: rtl/boe_pkg.sv
// Shared widths, FSM state encoding and the sort sentinel for the BOE frame transmitter.
package boe_pkg;

    localparam int MAX_N  = 6;
    localparam int DATA_W = 8;
    localparam int RES_W  = 11;
    localparam int NUM_W  = 3;

    localparam logic [DATA_W-1:0] SORT_FILL = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_CAPT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/boe_rx_capture.sv
// CAPT-phase demux: routes the BOE result stream into max, sum and sorted-element registers.
module boe_rx_capture
    import boe_pkg::*;
#(
    parameter int MAX_N = boe_pkg::MAX_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_W-1:0]        n,
    input  logic [RES_W-1:0]        result,
    output logic [DATA_W-1:0]       out_max,
    output logic [RES_W-1:0]        out_sum,
    output logic [MAX_N*DATA_W-1:0] out_sort,
    output logic                    cap_done
);

    logic                busy;
    logic [NUM_W:0]      j;
    logic [NUM_W-1:0]    sort_idx;
    logic [DATA_W-1:0]   sort_q [MAX_N];

    // Capture cycle 0 is the start cycle itself; j counts the remaining N+1 cycles.
    assign cap_done = busy && (j == ({1'b0, n} + (NUM_W+1)'(1)));
    assign sort_idx = NUM_W'(j - (NUM_W+1)'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= 1'b0;
            j       <= '0;
            out_max <= '0;
            out_sum <= '0;
            for (int k = 0; k < MAX_N; k++) sort_q[k] <= SORT_FILL;
        end else if (start) begin
            out_max <= result[DATA_W-1:0];
            busy    <= 1'b1;
            j       <= (NUM_W+1)'(1);
            for (int k = 0; k < MAX_N; k++) begin
                if (NUM_W'(k) >= n) sort_q[k] <= SORT_FILL;
            end
        end else if (busy) begin
            if (j == (NUM_W+1)'(1)) out_sum <= result;
            else                    sort_q[sort_idx] <= result[DATA_W-1:0];
            if (cap_done) busy <= 1'b0;
            else          j    <= j + (NUM_W+1)'(1);
        end
    end

    always_comb begin
        out_sort = '0;
        for (int k = 0; k < MAX_N; k++) out_sort[k*DATA_W +: DATA_W] = sort_q[k];
    end

endmodule

// File: rtl/boe_frame_tx.sv
// Frame transmitter: buffers up to MAX_N samples, streams them to BOE, captures max/sum/sort.
// Optional consistency checker on err is enabled by defining BOE_TX_CHECK_EN.
module boe_frame_tx
    import boe_pkg::*;
#(
    parameter int MAX_N    = boe_pkg::MAX_N,
    parameter int WAIT_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic [NUM_W-1:0]        data_num,
    output logic [DATA_W-1:0]       data_in,
    input  logic [RES_W-1:0]        result,
    output logic [NUM_W-1:0]        out_n,
    output logic [DATA_W-1:0]       out_max,
    output logic [RES_W-1:0]        out_sum,
    output logic [MAX_N*DATA_W-1:0] out_sort,
    output logic                    done,
    output logic                    err
);

    localparam int PH_W = 8;

    state_t            state, state_nx;
    logic [NUM_W-1:0]  count;
    logic [PH_W-1:0]   phase_cnt;
    logic [DATA_W-1:0] sample_buf [MAX_N];
    logic              start;
    logic              cap_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = ST_LOAD;
            ST_LOAD: if (in_valid && (in_last || count == NUM_W'(MAX_N-1))) state_nx = ST_SEND;
            ST_SEND: if (phase_cnt == PH_W'(count) - PH_W'(1)) state_nx = ST_WAIT;
            ST_WAIT: if (phase_cnt == PH_W'(WAIT_CYC-1)) state_nx = ST_CAPT;
            ST_CAPT: if (cap_done) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            phase_cnt <= '0;
            out_n     <= '0;
            // NOTE: the sample buffer is small and must read as zero in reset, so it is reset explicitly.
            for (int k = 0; k < MAX_N; k++) sample_buf[k] <= '0;
        end else begin
            // phase_cnt restarts on every state change and indexes SEND/WAIT/CAPT cycles.
            phase_cnt <= (state_nx != state) ? '0 : phase_cnt + PH_W'(1);
            if (state == ST_IDLE) count <= '0;
            if (in_ready && in_valid) begin
                sample_buf[count] <= in_data;
                count             <= count + NUM_W'(1);
            end
            if (start) out_n <= count;
        end
    end

    always_comb begin
        in_ready = (state == ST_LOAD);
        done     = (state == ST_DONE);
        data_num = '0;
        data_in  = '0;
        if (state == ST_SEND) begin
            data_in = sample_buf[phase_cnt[NUM_W-1:0]];
            if (phase_cnt == '0) data_num = count;
        end
    end

    assign start = (state == ST_CAPT) && (phase_cnt == '0);

    boe_rx_capture #(.MAX_N(MAX_N)) u_capture (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (count),
        .result   (result),
        .out_max  (out_max),
        .out_sum  (out_sum),
        .out_sort (out_sort),
        .cap_done (cap_done)
    );

`ifdef BOE_TX_CHECK_EN
    logic [DATA_W-1:0] exp_max, exp_min;
    logic [RES_W-1:0]  exp_sum;
    logic              err_q, mismatch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_max <= '0;
            exp_min <= '0;
            exp_sum <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_SEND) begin
                if (phase_cnt == '0) begin
                    exp_max <= data_in;
                    exp_min <= data_in;
                    exp_sum <= RES_W'(data_in);
                end else begin
                    if (data_in > exp_max) exp_max <= data_in;
                    if (data_in < exp_min) exp_min <= data_in;
                    exp_sum <= exp_sum + RES_W'(data_in);
                end
            end
            if (state == ST_LOAD && state_nx == ST_SEND) err_q <= 1'b0;
            else if (state == ST_DONE)                    err_q <= mismatch;
        end
    end

    // Sorted list must be ascending and bracket every sample between element 0 and element N-1.
    always_comb begin
        mismatch = (out_max != exp_max) || (out_sum != exp_sum) ||
                   (out_sort[DATA_W-1:0] > exp_min);
        for (int k = 1; k < MAX_N; k++) begin
            if (NUM_W'(k) < out_n &&
                out_sort[k*DATA_W +: DATA_W] < out_sort[(k-1)*DATA_W +: DATA_W]) mismatch = 1'b1;
        end
        for (int k = 0; k < MAX_N; k++) begin
            if (NUM_W'(k+1) == out_n && out_sort[k*DATA_W +: DATA_W] < exp_max) mismatch = 1'b1;
        end
    end

    assign err = err_q || (state == ST_DONE && mismatch);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_boe_frame_tx.sv
// Directed bench for boe_frame_tx with a behavioural BOE model answering max, sum, then sorted samples.
module tb_boe_frame_tx;

    localparam int WAIT_CYC = 1;

    logic        clk, rst;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  in_data, data_in, out_max;
    logic [2:0]  data_num, out_n;
    logic [10:0] result, out_sum;
    logic [47:0] out_sort;
    logic        done, err;
    bit          corrupt;

    int errors = 0;
    int checks = 0;

    boe_frame_tx #(.MAX_N(6), .WAIT_CYC(WAIT_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_data  (in_data),
        .in_ready (in_ready),
        .data_num (data_num),
        .data_in  (data_in),
        .result   (result),
        .out_n    (out_n),
        .out_max  (out_max),
        .out_sum  (out_sum),
        .out_sort (out_sort),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BOE model: records the streamed frame, then answers max, sum and ascending samples.
    initial begin : boe_model
        int          rel, mn, j;
        bit          act;
        logic [7:0]  smp [6];
        logic [7:0]  tmp;
        logic [10:0] vals [8];
        logic [10:0] s;
        logic [7:0]  m;
        act    = 1'b0;
        rel    = 0;
        mn     = 0;
        result = '0;
        forever begin
            @(negedge clk);
            result = '0;
            if (!rst) begin
                act = 1'b0;
            end else begin
                if (data_num != 0) begin
                    act = 1'b1;
                    rel = 0;
                    mn  = int'(data_num);
                end else if (act) begin
                    rel++;
                end
                if (act) begin
                    if (rel < mn) smp[rel] = data_in;
                    if (rel == mn - 1) begin
                        s = '0;
                        m = '0;
                        for (int a = 0; a < mn; a++) begin
                            s = s + 11'(smp[a]);
                            if (smp[a] > m) m = smp[a];
                        end
                        for (int a = 0; a < mn; a++) begin
                            for (int b = 0; b < mn - 1 - a; b++) begin
                                if (smp[b] > smp[b+1]) begin
                                    tmp = smp[b]; smp[b] = smp[b+1]; smp[b+1] = tmp;
                                end
                            end
                        end
                        vals[0] = 11'(m);
                        vals[1] = corrupt ? 11'd0 : s;
                        for (int a = 0; a < mn; a++) vals[a+2] = 11'(smp[a]);
                    end
                    j = rel - mn - WAIT_CYC;
                    if (j >= 0 && j <= mn + 1) result = vals[j];
                    if (j > mn + 1) act = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("send_ready_wait", 64'(t < 200), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the last sample is accepted; returns on the negedge one cycle after done.
    task automatic check_frame(input string tag, input int n, input logic [7:0] first,
                               input logic [7:0] emax, input logic [10:0] esum,
                               input logic [47:0] esort, input logic eerr);
        int rel;
        bit ready_seen;
        @(negedge clk);
        check({tag, "_data_num"}, 64'(data_num), 64'(n));
        check({tag, "_data_in0"}, 64'(data_in), 64'(first));
        check({tag, "_err_send"}, 64'(err), 64'd0);
        @(negedge clk);
        check({tag, "_data_num1"}, 64'(data_num), 64'd0);
        ready_seen = in_ready;
        rel = 1;
        while (!done && rel < 60) begin
            @(negedge clk);
            rel++;
            if (in_ready) ready_seen = 1'b1;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_latency"}, 64'(rel), 64'(2*n + WAIT_CYC + 2));
        check({tag, "_ready_busy"}, 64'(ready_seen), 64'd0);
        check({tag, "_out_n"}, 64'(out_n), 64'(n));
        check({tag, "_out_max"}, 64'(out_max), 64'(emax));
        check({tag, "_out_sum"}, 64'(out_sum), 64'(esum));
        check({tag, "_out_sort"}, 64'(out_sort), 64'(esort));
        check({tag, "_err"}, 64'(err), 64'(eerr));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin : stimulus
        bit done_seen;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        corrupt  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_data_num", 64'(data_num), 64'd0);
        check("rst_data_in", 64'(data_in), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_out_n", 64'(out_n), 64'd0);
        check("rst_out_max", 64'(out_max), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_sort", 64'(out_sort), 64'hFFFF_FFFF_FFFF);
        rst = 1'b1;

        // Full frame with in_last on the sixth sample.
        send(8'd10, 1'b0); send(8'd3, 1'b0); send(8'd7, 1'b0);
        send(8'd3, 1'b0);  send(8'd200, 1'b0); send(8'd1, 1'b1);
        check_frame("A", 6, 8'd10, 8'd200, 11'd224,
                    {8'd200, 8'd10, 8'd7, 8'd3, 8'd3, 8'd1}, 1'b0);

        // Single-sample frame: unused sort slots stay at the sentinel.
        send(8'd5, 1'b1);
        check_frame("B", 1, 8'd5, 8'd5, 11'd5, {40'hFF_FFFF_FFFF, 8'd5}, 1'b0);

        // Eight samples without in_last: frame closes at six, the rest start the next frame.
        send(8'd11, 1'b0); send(8'd22, 1'b0); send(8'd33, 1'b0);
        send(8'd44, 1'b0); send(8'd55, 1'b0); send(8'd66, 1'b0);
        check_frame("C", 6, 8'd11, 8'd66, 11'd231,
                    {8'd66, 8'd55, 8'd44, 8'd33, 8'd22, 8'd11}, 1'b0);
        check("C_ready_done1", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("C_ready_load", 64'(in_ready), 64'd1);
        send(8'd77, 1'b0); send(8'd88, 1'b0); send(8'd99, 1'b1);
        check_frame("C2", 3, 8'd77, 8'd99, 11'd264,
                    {24'hFF_FFFF, 8'd99, 8'd88, 8'd77}, 1'b0);

        // All-255 frame hits the largest possible sum.
        for (int i = 0; i < 6; i++) send(8'd255, (i == 5));
        check_frame("D", 6, 8'd255, 8'd255, 11'd1530, 48'hFFFF_FFFF_FFFF, 1'b0);

        // Reset during CAPT of a four-sample frame.
        send(8'd4, 1'b0); send(8'd8, 1'b0); send(8'd15, 1'b0); send(8'd16, 1'b1);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("E_rst_out_max", 64'(out_max), 64'd0);
        check("E_rst_out_sum", 64'(out_sum), 64'd0);
        check("E_rst_out_n", 64'(out_n), 64'd0);
        check("E_rst_out_sort", 64'(out_sort), 64'hFFFF_FFFF_FFFF);
        check("E_rst_data_num", 64'(data_num), 64'd0);
        done_seen = done;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("E_no_done", 64'(done_seen), 64'd0);
        rst = 1'b1;
        send(8'd2, 1'b0); send(8'd9, 1'b1);
        check_frame("F", 2, 8'd2, 8'd9, 11'd11, {32'hFFFF_FFFF, 8'd9, 8'd2}, 1'b0);

`ifdef BOE_TX_CHECK_EN
        // Sum result forced to zero on a frame summing to 50.
        corrupt = 1'b1;
        send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd20, 1'b1);
        check_frame("G", 3, 8'd10, 8'd20, 11'd0, {24'hFF_FFFF, 8'd20, 8'd20, 8'd10}, 1'b1);
        corrupt = 1'b0;
        check("G_err_hold", 64'(err), 64'd1);
        send(8'd1, 1'b0); send(8'd2, 1'b1);
        check_frame("H", 2, 8'd1, 8'd2, 11'd3, {32'hFFFF_FFFF, 8'd2, 8'd1}, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
